// File: rtl/laser_hit_judge.sv
// Hit/miss judge for one laser sample per frame: compares the laser centroid
// against a latched target, keeps score and miss count, and paces rounds.
module laser_hit_judge #(
  parameter int CW         = 10,
  parameter int HIT_RADIUS = 8,
  parameter int DWELL      = 3,
  parameter int TIMEOUT    = 300,
  parameter int COOLDOWN   = 30,
  parameter int SCORE_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               coord_valid,
  input  logic [31:0]        x_actual,
  input  logic [31:0]        y_actual,
  input  logic [31:0]        x_target,
  input  logic [31:0]        y_target,
  output logic [1:0]         state,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] miss_count
);

  localparam logic [1:0] S_IDLE     = 2'b00;
  localparam logic [1:0] S_ARMED    = 2'b01;
  localparam logic [1:0] S_COOLDOWN = 2'b10;

  localparam int DW = $clog2(DWELL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int KW = $clog2(COOLDOWN + 1);

  localparam logic [DW-1:0] DWELL_L    = DW'(DWELL);
  localparam logic [TW-1:0] TIMEOUT_L  = TW'(TIMEOUT);
  localparam logic [KW-1:0] COOLDOWN_L = KW'(COOLDOWN);
  localparam logic [CW-1:0] RADIUS_L   = CW'(HIT_RADIUS);

  logic [1:0]         state_q, state_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [TW-1:0]      round_q, round_d;
  logic [KW-1:0]      cool_q, cool_d;
  logic [CW-1:0]      tx_q, tx_d;
  logic [CW-1:0]      ty_q, ty_d;

  logic [CW-1:0] x_now, y_now, dx, dy;
  logic          present, on_target;

  // Only the low CW bits of the target take part in the comparison.
  logic unused_target_hi;
  assign unused_target_hi = ^{x_target[31:CW], y_target[31:CW]};

  assign x_now = x_actual[CW-1:0];
  assign y_now = y_actual[CW-1:0];

  always_comb begin
    // Larger minus smaller, so a target near 0 never wraps into a small distance.
    dx        = (x_now >= tx_q) ? (x_now - tx_q) : (tx_q - x_now);
    dy        = (y_now >= ty_q) ? (y_now - ty_q) : (ty_q - y_now);
    present   = (x_actual != '0) || (y_actual != '0);
    on_target = present && (dx <= RADIUS_L) && (dy <= RADIUS_L);
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can
    // leave it unassigned, which would infer a latch.
    state_d    = state_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    dwell_d    = dwell_q;
    round_d    = round_q;
    cool_d     = cool_q;
    tx_d       = tx_q;
    ty_d       = ty_q;

    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_ARMED;
            score_d    = '0;
            miss_cnt_d = '0;
            dwell_d    = '0;
            round_d    = '0;
            cool_d     = '0;
            tx_d       = x_target[CW-1:0];
            ty_d       = y_target[CW-1:0];
          end
        end
        S_ARMED: begin
          if (coord_valid) begin
            round_d = round_q + TW'(1);
            dwell_d = on_target ? (dwell_q + DW'(1)) : '0;
            // A hit on the final sample of the round takes precedence over timeout.
            if (on_target && (dwell_q + DW'(1) == DWELL_L)) begin
              hit_d   = 1'b1;
              score_d = (&score_q) ? score_q : (score_q + SCORE_W'(1));
              state_d = S_COOLDOWN;
              cool_d  = '0;
            end else if (round_q + TW'(1) == TIMEOUT_L) begin
              miss_d     = 1'b1;
              miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : (miss_cnt_q + SCORE_W'(1));
              state_d    = S_COOLDOWN;
              cool_d     = '0;
            end
          end
        end
        S_COOLDOWN: begin
          if (coord_valid) begin
            if (cool_q + KW'(1) == COOLDOWN_L) begin
              state_d = S_ARMED;
              dwell_d = '0;
              round_d = '0;
              cool_d  = '0;
              tx_d    = x_target[CW-1:0];
              ty_d    = y_target[CW-1:0];
            end else begin
              cool_d = cool_q + KW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      score_q    <= '0;
      miss_cnt_q <= '0;
      dwell_q    <= '0;
      round_q    <= '0;
      cool_q     <= '0;
      tx_q       <= '0;
      ty_q       <= '0;
    end else begin
      state_q    <= state_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
      dwell_q    <= dwell_d;
      round_q    <= round_d;
      cool_q     <= cool_d;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
    end
  end

  assign state      = state_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign score      = score_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_laser_hit_judge.sv
// Directed bench for laser_hit_judge: default instance plus a short-timeout
// instance (TIMEOUT=3, DWELL=3) sharing the same stimulus.
module tb_laser_hit_judge;

  logic        clk = 1'b0;
  logic        reset, start, stop, coord_valid;
  logic [31:0] x_actual, y_actual, x_target, y_target;

  logic [1:0]  state, state_b;
  logic        hit, miss, hit_b, miss_b;
  logic [15:0] score, miss_count, score_b, miss_count_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  laser_hit_judge u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .coord_valid(coord_valid),
    .x_actual(x_actual), .y_actual(y_actual), .x_target(x_target), .y_target(y_target),
    .state(state), .hit(hit), .miss(miss), .score(score), .miss_count(miss_count)
  );

  laser_hit_judge #(.TIMEOUT(3), .DWELL(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .coord_valid(coord_valid),
    .x_actual(x_actual), .y_actual(y_actual), .x_target(x_target), .y_target(y_target),
    .state(state_b), .hit(hit_b), .miss(miss_b), .score(score_b), .miss_count(miss_count_b)
  );

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic drive(input logic [31:0] x, input logic [31:0] y,
                       input logic cv, input logic st, input logic sp);
    x_actual = x; y_actual = y; coord_valid = cv; start = st; stop = sp;
    @(posedge clk);
    #1;
    coord_valid = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic samp(input logic [31:0] x, input logic [31:0] y);
    drive(x, y, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic leave_cooldown();
    repeat (29) samp(32'd0, 32'd0);
    total++; if (state !== 2'b10) begin bad++; $display("FAIL cool_29th: state=%0d want 2", state); end
    samp(32'd0, 32'd0);
    total++; if (state !== 2'b01) begin bad++; $display("FAIL cool_30th: state=%0d want 1", state); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: state=%0d want 0", state); end
    total++; if ({hit, miss} !== 2'b00) begin bad++; $display("FAIL reset_pulses: hit=%0b miss=%0b want 0", hit, miss); end
    total++; if ({score, miss_count} !== 32'd0) begin bad++; $display("FAIL reset_counts: score=%0d miss_count=%0d want 0", score, miss_count); end
    reset = 1'b0;
  endtask

  task automatic test_basic_hit();
    x_target = 32'd100; y_target = 32'd100;
    drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    total++; if (state !== 2'b01) begin bad++; $display("FAIL start_armed: state=%0d want 1", state); end
    samp(32'd104, 32'd97);
    samp(32'd104, 32'd97);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL hit_2nd: hit=%0b want 0", hit); end
    samp(32'd104, 32'd97);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL hit_3rd: hit=%0b want 1", hit); end
    total++; if (score !== 16'd1) begin bad++; $display("FAIL hit_score: score=%0d want 1", score); end
    total++; if (state !== 2'b10) begin bad++; $display("FAIL hit_state: state=%0d want 2", state); end
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL hit_pulse_width: hit=%0b want 0", hit); end
    leave_cooldown();
  endtask

  task automatic test_dwell_restart();
    samp(32'd104, 32'd97);
    samp(32'd150, 32'd150);
    samp(32'd104, 32'd97);
    repeat (5) drive(32'd104, 32'd97, 1'b0, 1'b0, 1'b0);
    samp(32'd104, 32'd97);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL dwell_restart: hit=%0b want 0", hit); end
    samp(32'd0, 32'd0);
    samp(32'd96, 32'd108);
    samp(32'd96, 32'd108);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL dwell_after_zero: hit=%0b want 0", hit); end
    samp(32'd96, 32'd108);
    total++; if (hit !== 1'b1 || score !== 16'd2) begin bad++; $display("FAIL dwell_hit: hit=%0b score=%0d want 1/2", hit, score); end
    x_target = 32'd3; y_target = 32'd3;
    leave_cooldown();
  endtask

  task automatic test_edges();
    samp(32'd0, 32'd0);
    samp(32'd3, 32'd3);
    samp(32'd3, 32'd3);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL no_laser_counted: hit=%0b want 0", hit); end
    samp(32'd250, 32'd3);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL far_x_250: hit=%0b want 0", hit); end
    samp(32'd3, 32'd3);
    samp(32'd3, 32'd3);
    samp(32'd1020, 32'd3);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL no_wrap_1020: hit=%0b want 0", hit); end
    samp(32'd3, 32'd3);
    samp(32'd3, 32'd3);
    samp(32'd12, 32'd3);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL dx_9: hit=%0b want 0", hit); end
    samp(32'd11, 32'd3);
    samp(32'd3, 32'd11);
    samp(32'd11, 32'd11);
    total++; if (hit !== 1'b1 || score !== 16'd3) begin bad++; $display("FAIL dx_8_hit: hit=%0b score=%0d want 1/3", hit, score); end
    x_target = 32'd500; y_target = 32'd600;
    leave_cooldown();
  endtask

  task automatic test_timeout();
    x_target = 32'd100; y_target = 32'd100;
    repeat (299) samp(32'd100, 32'd100);
    total++; if (miss !== 1'b0 || state !== 2'b01) begin bad++; $display("FAIL timeout_299: miss=%0b state=%0d want 0/1", miss, state); end
    samp(32'd100, 32'd100);
    total++; if (miss !== 1'b1 || miss_count !== 16'd1) begin bad++; $display("FAIL timeout_300: miss=%0b miss_count=%0d want 1/1", miss, miss_count); end
    total++; if (state !== 2'b10 || score !== 16'd3) begin bad++; $display("FAIL timeout_state: state=%0d score=%0d want 2/3", state, score); end
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    total++; if (miss !== 1'b0) begin bad++; $display("FAIL miss_pulse_width: miss=%0b want 0", miss); end
    x_target = 32'd700; y_target = 32'd700;
    leave_cooldown();
    x_target = 32'd0; y_target = 32'd0;
    repeat (3) samp(32'd702, 32'd698);
    total++; if (hit !== 1'b1 || score !== 16'd4) begin bad++; $display("FAIL relatch_hit: hit=%0b score=%0d want 1/4", hit, score); end
  endtask

  task automatic test_hit_beats_timeout();
    reset = 1'b1;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    total++; if (state_b !== 2'b00 || score_b !== 16'd0) begin bad++; $display("FAIL b_reset: state=%0d score=%0d want 0/0", state_b, score_b); end
    reset = 1'b0;
    x_target = 32'd100; y_target = 32'd100;
    drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    samp(32'd100, 32'd100);
    samp(32'd100, 32'd100);
    total++; if (hit_b !== 1'b0 || miss_b !== 1'b0) begin bad++; $display("FAIL b_2nd: hit=%0b miss=%0b want 0/0", hit_b, miss_b); end
    samp(32'd100, 32'd100);
    total++; if (hit_b !== 1'b1 || miss_b !== 1'b0) begin bad++; $display("FAIL b_hit_wins: hit=%0b miss=%0b want 1/0", hit_b, miss_b); end
    total++; if (miss_count_b !== 16'd0 || score_b !== 16'd1) begin bad++; $display("FAIL b_counts: miss_count=%0d score=%0d want 0/1", miss_count_b, score_b); end
    leave_cooldown();
    repeat (3) samp(32'd300, 32'd300);
    total++; if (miss_b !== 1'b1 || miss_count_b !== 16'd1) begin bad++; $display("FAIL b_timeout: miss=%0b miss_count=%0d want 1/1", miss_b, miss_count_b); end
  endtask

  task automatic test_stop_and_reset();
    samp(32'd100, 32'd100);
    samp(32'd100, 32'd100);
    drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    total++; if (state !== 2'b01) begin bad++; $display("FAIL start_in_armed: state=%0d want 1", state); end
    samp(32'd100, 32'd100);
    total++; if (hit !== 1'b1 || score !== 16'd2) begin bad++; $display("FAIL start_ignored_hit: hit=%0b score=%0d want 1/2", hit, score); end
    leave_cooldown();
    samp(32'd100, 32'd100);
    samp(32'd100, 32'd100);
    drive(32'd100, 32'd100, 1'b1, 1'b0, 1'b1);
    total++; if (hit !== 1'b0 || state !== 2'b00) begin bad++; $display("FAIL stop_suppress: hit=%0b state=%0d want 0/0", hit, state); end
    total++; if (score !== 16'd2) begin bad++; $display("FAIL stop_score_hold: score=%0d want 2", score); end
    drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL start_stop_idle: state=%0d want 0", state); end
    drive(32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    total++; if (state !== 2'b01 || score !== 16'd0) begin bad++; $display("FAIL restart_clear: state=%0d score=%0d want 1/0", state, score); end
    repeat (3) samp(32'd100, 32'd100);
    repeat (5) samp(32'd0, 32'd0);
    total++; if (state !== 2'b10 || score !== 16'd1) begin bad++; $display("FAIL pre_reset: state=%0d score=%0d want 2/1", state, score); end
    reset = 1'b1;
    drive(32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    total++; if ({state, hit, miss, score, miss_count} !== 36'd0) begin bad++; $display("FAIL reset_mid_cool: state=%0d score=%0d miss_count=%0d want 0", state, score, miss_count); end
    reset = 1'b0;
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    total++; if (state !== 2'b00) begin bad++; $display("FAIL post_reset_idle: state=%0d want 0", state); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; coord_valid = 1'b0;
    x_actual = '0; y_actual = '0; x_target = '0; y_target = '0;
    test_reset();
    test_basic_hit();
    test_dwell_restart();
    test_edges();
    test_timeout();
    test_hit_beats_timeout();
    test_stop_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
